sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between the instruction-fetch unit (m0) and the data-memory unit (m1).
- Arbitrates with round-robin priority and keeps exactly one transaction outstanding on the bus.
- Forwards the address and write-data phases from the winner, then routes response beats back to that winner only.
- Sits between Core's front-end/LSU and the top-level Sysbus; it becomes the only logic that drives bus.req*.

Parameters:
BEATS, 8, 64-bit beats per line transfer (read response or write data)
TIMEOUT, 1024, max cycles in RWAIT before abort
TAGW, 13, reqtag/resptag width: {rw[12], type[11:8], id[7:0]}

Ports:
clk  input  1  bus clock
reset_n  input  1  asynchronous, active-low reset
m_reqcyc  input  2  per-requester request valid (bit0 fetch, bit1 data)
m_req  input  2x64  per-requester address, or write data in WDATA
m_reqtag  input  2xTAGW  per-requester tag
m_reqack  output  2  per-requester request/beat accepted
m_respcyc  output  2  per-requester response beat valid
m_resp  output  64  response data, shared by both requesters
m_respack  input  2  per-requester response beat accepted
bus_reqcyc  output  1  to Sysbus
bus_req  output  64  to Sysbus
bus_reqtag  output  TAGW  to Sysbus
bus_reqack  input  1  from Sysbus
bus_respcyc  input  1  from Sysbus
bus_resp  input  64  from Sysbus
bus_resptag  input  TAGW  from Sysbus
bus_respack  output  1  to Sysbus
busy  output  1  state != IDLE
err  output  1  sticky error: timeout, tag mismatch or stray response

Behaviour:
- Registered state: state, owner (1b), last_grant (1b), beat_cnt (log2 BEATS + 1 bits), tmo_cnt (16b), lat_tag (TAGW), err.
- All bus/m_* outputs are combinational from state and owner. In IDLE every output is 0 except bus_respack (see stray response).
- Reset (reset_n=0, async, any cycle including mid-burst): state=IDLE, last_grant=1 (so m0 wins first), counters=0, err=0. All outputs are 0 immediately.
- IDLE:
  - If any m_reqcyc is set, pick a winner: the only requester, or on a tie the one != last_grant.
  - Latch owner and m_reqtag[winner]; go to GRANT. Arbitration costs 1 cycle.
- GRANT:
  - bus_reqcyc/req/reqtag = m_*[owner]; m_reqack[owner] = bus_reqack.
  - On ack: if lat_tag[12]=WRITE go to WDATA with beat_cnt=0, else go to RWAIT with tmo_cnt=0.
  - If m_reqcyc[owner] drops before ack: go to IDLE; last_grant is unchanged.
- WDATA:
  - Same passthrough as GRANT. Each cycle with bus_reqcyc & bus_reqack increments beat_cnt.
  - At the BEATS-th beat: go to IDLE and set last_grant=owner.
- RWAIT/RDATA:
  - m_respcyc[owner]=bus_respcyc; m_resp=bus_resp; bus_respack=m_respack[owner]; the other requester sees 0.
  - The first bus_respcyc moves RWAIT to RDATA in that same cycle, and that beat is routed.
  - A beat counts when bus_respcyc & bus_respack. At the BEATS-th beat: go to IDLE and set last_grant=owner.
  - bus_resptag[7:0] != lat_tag[7:0] on any beat sets err; the beat is still routed.
  - RWAIT with tmo_cnt == TIMEOUT-1 and no respcyc: set err, go to IDLE, set last_grant=owner.
  - bus_respcyc falling before BEATS: hold state, wait.
- Stray response: bus_respcyc in IDLE/GRANT/WDATA gives bus_respack=1 (drain) and sets err; nothing is routed.
- beat_cnt compares against BEATS without wrap. tmo_cnt saturates.

Decomposition:
- Package sysbus_pkg holds:
  - state enum {IDLE, GRANT, WDATA, RWAIT, RDATA}
  - READ=0/WRITE=1
  - MEMORY type code
  - tag field offsets
  - BEATS default
- Sub-module rr_arbiter2 (req[1:0], last_grant → grant_valid, winner) holds the pick logic.

Test Plan:
- Fetch read alone: m0 reqcyc, addr 0x1000, tag id 0x00; bus acks 2 cycles later, 8 beats 0x10..0x17 → m_respcyc[0] 8 times with that data, m_reqack[1]/m_respcyc[1] stay 0, busy falls after beat 8, err=0.
- Simultaneous requests from reset: m0 and m1 both read → m0 served first, m1 gets GRANT in the cycle after m0's last beat + 1; third tie → m0 again.
- Data write: m1 tag WRITE, addr 0x2040, then 8 data beats with ack stalls of 1 cycle → bus_req carries addr then data 0xA0..0xA7 in order, exactly 8 counted beats, no response phase, next state IDLE.
- Timeout: read acked, no response for TIMEOUT cycles → err=1 at cycle TIMEOUT, state IDLE, pending m1 request granted next.
- Stray/mismatch: bus_respcyc in IDLE → bus_respack=1, err=1; separately, resptag id 0x05 vs latched 0x00 → data still routed, err=1.
- Async reset mid-RDATA at beat 3 → all outputs 0 within the reset cycle, busy=0, err=0; first post-reset tie is granted to m0.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared definitions for the Sysbus arbiter slice.
//   state_t      : arbiter transaction phases
//   READ / WRITE : value of the rw bit in a request tag
//   TYPE_MEMORY  : tag type code for ordinary memory traffic
//   TAG_*        : bit positions of the {rw, type, id} tag fields
//   *_DEFAULT    : default parameter values for sysbus_arbiter
package sysbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WDATA,
    RWAIT,
    RDATA
  } state_t;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [3:0] TYPE_MEMORY = 4'h1;

  localparam int unsigned TAG_RW_BIT   = 12;
  localparam int unsigned TAG_TYPE_LSB = 8;
  localparam int unsigned TAG_TYPE_W   = 4;
  localparam int unsigned TAG_ID_LSB   = 0;
  localparam int unsigned TAG_ID_W     = 8;

  localparam int unsigned BEATS_DEFAULT   = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;
  localparam int unsigned TAGW_DEFAULT    = 13;

endpackage

// File: rtl/sysbus_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick.
//   req[1:0]    : request lines (bit0 fetch, bit1 data)
//   last_grant  : requester that completed the previous transaction
//   grant_valid : at least one request is present
//   winner      : selected requester index
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       winner
);

  always_comb begin
    grant_valid = |req;
    // On a tie the requester that did not finish last goes first.
    winner      = (req == 2'b11) ? ~last_grant : req[1];
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: shares the Sysbus master port between fetch (m0) and
// data (m1), one outstanding transaction at a time, round-robin priority.
//   clk, reset_n              : clock, async active-low reset
//   m_reqcyc/m_req/m_reqtag   : per-requester request valid, addr/wdata, tag
//   m_reqack                  : per-requester request/beat accepted
//   m_respcyc/m_resp          : per-requester response valid, shared data
//   m_respack                 : per-requester response accepted
//   bus_req*/bus_resp*        : Sysbus master side
//   busy                      : a transaction is in progress
//   err                       : sticky timeout / tag mismatch / stray response
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int unsigned BEATS   = BEATS_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned TAGW    = TAGW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           m_reqcyc,
  input  logic [1:0][63:0]     m_req,
  input  logic [1:0][TAGW-1:0] m_reqtag,
  output logic [1:0]           m_reqack,
  output logic [1:0]           m_respcyc,
  output logic [63:0]          m_resp,
  input  logic [1:0]           m_respack,
  output logic                 bus_reqcyc,
  output logic [63:0]          bus_req,
  output logic [TAGW-1:0]      bus_reqtag,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [63:0]          bus_resp,
  input  logic [TAGW-1:0]      bus_resptag,
  output logic                 bus_respack,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned     CNTW      = $clog2(BEATS) + 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);
  localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);

  state_t          r_state, w_state_nxt;
  logic            r_owner, w_owner_nxt;
  logic            r_last_grant, w_last_grant_nxt;
  logic [CNTW-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [15:0]     r_tmo_cnt, w_tmo_cnt_nxt;
  logic [TAGW-1:0] r_lat_tag, w_lat_tag_nxt;
  logic            r_err, w_err_nxt;

  logic w_grant_valid;
  logic w_winner;
  logic w_rd_phase;
  logic w_beat_wr;
  logic w_beat_rd;
  logic w_last_beat;
  logic w_id_mismatch;
  logic w_unused;

  rr_arbiter2 u_rr (
    .req         (m_reqcyc),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .winner      (w_winner)
  );

  assign w_rd_phase    = (r_state == RWAIT) || (r_state == RDATA);
  assign w_beat_wr     = m_reqcyc[r_owner] & bus_reqack;
  assign w_beat_rd     = bus_respcyc & m_respack[r_owner];
  assign w_last_beat   = (r_beat_cnt == LAST_BEAT);
  assign w_id_mismatch = bus_resptag[TAG_ID_LSB +: TAG_ID_W] != r_lat_tag[TAG_ID_LSB +: TAG_ID_W];
  assign w_unused      = ^{bus_resptag[TAG_RW_BIT:TAG_TYPE_LSB], r_lat_tag[TAG_TYPE_LSB +: TAG_TYPE_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_lat_tag    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_lat_tag    <= w_lat_tag_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_lat_tag_nxt    = r_lat_tag;
    w_err_nxt        = r_err;

    if (bus_respcyc && !w_rd_phase) begin
      w_err_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_owner_nxt   = w_winner;
          w_lat_tag_nxt = m_reqtag[w_winner];
          w_state_nxt   = GRANT;
        end
      end
      GRANT: begin
        if (!m_reqcyc[r_owner]) begin
          w_state_nxt = IDLE;
        end else if (bus_reqack) begin
          w_beat_cnt_nxt = '0;
          w_tmo_cnt_nxt  = '0;
          w_state_nxt    = (r_lat_tag[TAG_RW_BIT] == WRITE) ? WDATA : RWAIT;
        end
      end
      WDATA: begin
        if (w_beat_wr) begin
          if (w_last_beat) begin
            w_state_nxt      = IDLE;
            w_last_grant_nxt = r_owner;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      RWAIT, RDATA: begin
        if (bus_respcyc) begin
          if (w_id_mismatch) begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = RDATA;
          if (w_beat_rd) begin
            if (w_last_beat) begin
              w_state_nxt      = IDLE;
              w_last_grant_nxt = r_owner;
            end else begin
              w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            end
          end
        end else if (r_state == RWAIT) begin
          if (r_tmo_cnt == TMO_LAST) begin
            w_err_nxt        = 1'b1;
            w_state_nxt      = IDLE;
            w_last_grant_nxt = r_owner;
          end else if (r_tmo_cnt != '1) begin
            w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output routing, purely from state and owner.
  always_comb begin
    m_reqack    = '0;
    m_respcyc   = '0;
    m_resp      = '0;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;

    if (r_state == GRANT || r_state == WDATA) begin
      bus_reqcyc          = m_reqcyc[r_owner];
      bus_req             = m_req[r_owner];
      bus_reqtag          = m_reqtag[r_owner];
      m_reqack[r_owner]   = bus_reqack;
    end

    if (w_rd_phase) begin
      m_respcyc[r_owner] = bus_respcyc;
      m_resp             = bus_resp;
      bus_respack        = m_respack[r_owner];
    end else begin
      // Stray beats are drained; gated so every output is 0 while in reset.
      bus_respack = bus_respcyc & reset_n;
    end
  end

  assign busy = (r_state != IDLE);
  assign err  = r_err;

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;

  localparam int BEATS   = 8;
  localparam int TIMEOUT = 1024;
  localparam int TAGW    = 13;
  localparam logic [3:0] MEM = 4'h1;

  logic                 clk;
  logic                 reset_n;
  logic [1:0]           m_reqcyc;
  logic [1:0][63:0]     m_req;
  logic [1:0][TAGW-1:0] m_reqtag;
  logic [1:0]           m_reqack;
  logic [1:0]           m_respcyc;
  logic [63:0]          m_resp;
  logic [1:0]           m_respack;
  logic                 bus_reqcyc;
  logic [63:0]          bus_req;
  logic [TAGW-1:0]      bus_reqtag;
  logic                 bus_reqack;
  logic                 bus_respcyc;
  logic [63:0]          bus_resp;
  logic [TAGW-1:0]      bus_resptag;
  logic                 bus_respack;
  logic                 busy;
  logic                 err;

  sysbus_arbiter #(.BEATS(BEATS), .TIMEOUT(TIMEOUT), .TAGW(TAGW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_reqcyc    (m_reqcyc),
    .m_req       (m_req),
    .m_reqtag    (m_reqtag),
    .m_reqack    (m_reqack),
    .m_respcyc   (m_respcyc),
    .m_resp      (m_resp),
    .m_respack   (m_respack),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack),
    .busy        (busy),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one current transaction, described by who owns
  // it, whether its address was taken, and how far its data has progressed.
  bit       mb_busy, mb_owner, mb_rw, mb_adone, mb_started, mb_last, mb_err;
  int       mb_beats, mb_wait;
  logic [7:0] mb_id;

  // Random requester/bus agents.
  bit             rnd_on = 0;
  int             ag_ph [2];   // 0 idle, 1 address, 2 write data, 3 read wait
  int             ag_cnt[2];
  logic [63:0]    ag_addr[2];
  logic [TAGW-1:0] ag_tag[2];

  task automatic model_reset();
    mb_busy = 0; mb_owner = 0; mb_rw = 0; mb_adone = 0; mb_started = 0;
    mb_last = 1; mb_err = 0; mb_beats = 0; mb_wait = 0; mb_id = '0;
  endtask

  task automatic end_txn();
    mb_busy = 0;
    mb_last = mb_owner;
  endtask

  task automatic model_cycle();
    logic            o, rd, w;
    logic [1:0]      e_reqack, e_respcyc;
    logic            e_reqcyc, e_respack, e_busy, e_err;
    logic [63:0]     e_req, e_resp;
    logic [TAGW-1:0] e_tag;
    e_reqack = '0; e_respcyc = '0; e_reqcyc = 0; e_respack = 0; e_busy = 0; e_err = 0;
    e_req = '0; e_resp = '0; e_tag = '0;
    o  = mb_owner;
    rd = mb_busy && mb_adone && !mb_rw;
    if (reset_n) begin
      if (mb_busy && !rd) begin
        e_reqcyc    = m_reqcyc[o];
        e_req       = m_req[o];
        e_tag       = m_reqtag[o];
        e_reqack[o] = bus_reqack;
      end
      if (rd) begin
        e_respcyc[o] = bus_respcyc;
        e_resp       = bus_resp;
        e_respack    = m_respack[o];
      end else begin
        e_respack = bus_respcyc;
      end
      e_busy = mb_busy;
      e_err  = mb_err;
    end
    chk("bus_reqcyc",  64'(bus_reqcyc),  64'(e_reqcyc));
    chk("bus_req",     bus_req,          e_req);
    chk("bus_reqtag",  64'(bus_reqtag),  64'(e_tag));
    chk("m_reqack",    64'(m_reqack),    64'(e_reqack));
    chk("m_respcyc",   64'(m_respcyc),   64'(e_respcyc));
    chk("m_resp",      m_resp,           e_resp);
    chk("bus_respack", 64'(bus_respack), 64'(e_respack));
    chk("busy",        64'(busy),        64'(e_busy));
    chk("err",         64'(err),         64'(e_err));

    if (!reset_n) begin
      model_reset();
    end else begin
      if (bus_respcyc && !rd) mb_err = 1;
      if (!mb_busy) begin
        if (m_reqcyc != 2'b00) begin
          w = (m_reqcyc == 2'b11) ? !mb_last : m_reqcyc[1];
          mb_busy = 1; mb_owner = w; mb_adone = 0;
          mb_rw = m_reqtag[w][12]; mb_id = m_reqtag[w][7:0];
        end
      end else if (!mb_adone) begin
        if (!m_reqcyc[o]) mb_busy = 0;
        else if (bus_reqack) begin
          mb_adone = 1; mb_beats = 0; mb_wait = 0; mb_started = 0;
        end
      end else if (mb_rw) begin
        if (m_reqcyc[o] && bus_reqack) begin
          mb_beats++;
          if (mb_beats == BEATS) end_txn();
        end
      end else begin
        if (bus_respcyc) begin
          mb_started = 1;
          if (bus_resptag[7:0] != mb_id) mb_err = 1;
          if (m_respack[o]) begin
            mb_beats++;
            if (mb_beats == BEATS) end_txn();
          end
        end else if (!mb_started) begin
          if (mb_wait == TIMEOUT - 1) begin
            mb_err = 1;
            end_txn();
          end else begin
            mb_wait++;
          end
        end
      end
    end

    if (rnd_on) begin
      for (int i = 0; i < 2; i++) begin
        if (ag_ph[i] == 1 && m_reqcyc[i] && e_reqack[i]) begin
          ag_ph[i]  = ag_tag[i][12] ? 2 : 3;
          ag_cnt[i] = 0;
        end else if (ag_ph[i] == 2 && m_reqcyc[i] && e_reqack[i]) begin
          ag_cnt[i]++;
          if (ag_cnt[i] == BEATS) ag_ph[i] = 0;
        end else if (ag_ph[i] == 3 && !(mb_busy && mb_owner == i)) begin
          ag_ph[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_inputs();
    bit rd;
    rd = mb_busy && mb_adone && !mb_rw;
    for (int i = 0; i < 2; i++) begin
      if (ag_ph[i] == 0 && $urandom_range(3) == 0) begin
        ag_ph[i]   = 1;
        ag_addr[i] = {$urandom, $urandom};
        ag_tag[i]  = {1'($urandom_range(1)), MEM, 8'($urandom)};
      end else if (ag_ph[i] == 1 && $urandom_range(49) == 0) begin
        ag_ph[i] = 0;
      end
      case (ag_ph[i])
        1:       begin m_reqcyc[i] = 1'b1; m_req[i] = ag_addr[i]; end
        2:       begin m_reqcyc[i] = ($urandom_range(3) != 0); m_req[i] = {$urandom, $urandom}; end
        default: begin m_reqcyc[i] = 1'b0; m_req[i] = {$urandom, $urandom}; end
      endcase
      m_reqtag[i]  = ag_tag[i];
      m_respack[i] = ($urandom_range(4) != 0);
    end
    bus_reqack  = ($urandom_range(2) != 0);
    bus_respcyc = rd ? ($urandom_range(3) != 0) : ($urandom_range(99) == 0);
    bus_resp    = {$urandom, $urandom};
    bus_resptag = ($urandom_range(29) == 0) ? TAGW'($urandom) : {1'b0, MEM, mb_id};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_reqcyc = '0; m_req = '0; m_reqtag = '0; m_respack = 2'b11;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    ag_ph[0] = 0; ag_ph[1] = 0;
    #1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Serves one read whose requester is already raising m_reqcyc, arbiter idle.
  task automatic serve_read(input int w, input logic [63:0] exp_addr, input logic [7:0] id,
                            input int ack_dly, input string nm);
    logic [1:0] own;
    own = (w == 0) ? 2'b01 : 2'b10;
    bus_reqack = 0; bus_respcyc = 0; m_respack = 2'b11;
    step();
    chk({nm, "_grant_addr"}, bus_req, exp_addr);
    chk({nm, "_grant_busy"}, 64'(busy), 64'd1);
    for (int d = 0; d < ack_dly; d++) step();
    bus_reqack = 1;
    #1;
    chk({nm, "_reqack"}, 64'(m_reqack), 64'(own));
    step();
    bus_reqack = 0;
    m_reqcyc[w] = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      bus_respcyc = 1;
      bus_resp    = 64'h10 + 64'(k);
      bus_resptag = {1'b0, MEM, id};
      #1;
      chk({nm, "_resp"}, m_resp, 64'h10 + 64'(k));
      chk({nm, "_respcyc"}, 64'(m_respcyc), 64'(own));
      step();
    end
    bus_respcyc = 0;
    #1;
    chk({nm, "_done_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_reqcyc", 64'(bus_reqcyc), 64'd0);

    // Fetch read alone, ack two cycles after the request.
    m_reqcyc = 2'b01; m_req[0] = 64'h1000; m_reqtag[0] = {1'b0, MEM, 8'h00};
    serve_read(0, 64'h1000, 8'h00, 1, "fetch");
    chk("fetch_err", 64'(err), 64'd0);

    // Round-robin ties from reset.
    do_reset();
    m_reqcyc = 2'b11;
    m_req[0] = 64'h1100; m_reqtag[0] = {1'b0, MEM, 8'h01};
    m_req[1] = 64'h2200; m_reqtag[1] = {1'b0, MEM, 8'h02};
    serve_read(0, 64'h1100, 8'h01, 0, "tie1");
    serve_read(1, 64'h2200, 8'h02, 0, "tie2");
    m_reqcyc = 2'b11;
    serve_read(0, 64'h1100, 8'h01, 0, "tie3");

    // Data write with one-cycle ack stalls per beat.
    do_reset();
    m_reqcyc = 2'b10; m_req[1] = 64'h2040; m_reqtag[1] = {1'b1, MEM, 8'h07};
    step();
    bus_reqack = 1;
    #1;
    chk("wr_addr", bus_req, 64'h2040);
    chk("wr_addr_ack", 64'(m_reqack), 64'b10);
    step();
    for (int k = 0; k < BEATS; k++) begin
      m_req[1] = 64'hA0 + 64'(k);
      bus_reqack = 0;
      step();
      bus_reqack = 1;
      #1;
      chk("wr_data", bus_req, 64'hA0 + 64'(k));
      chk("wr_data_ack", 64'(m_reqack), 64'b10);
      step();
    end
    m_reqcyc = 2'b00; bus_reqack = 0;
    #1;
    chk("wr_done_busy", 64'(busy), 64'd0);
    chk("wr_done_err", 64'(err), 64'd0);

    // Read timeout with m1 waiting behind it.
    do_reset();
    m_reqcyc = 2'b11;
    m_req[0] = 64'h7000; m_reqtag[0] = {1'b0, MEM, 8'h01};
    m_req[1] = 64'h8000; m_reqtag[1] = {1'b0, MEM, 8'h02};
    step();
    bus_reqack = 1;
    step();
    bus_reqack = 0; m_reqcyc = 2'b10;
    for (int c = 0; c < TIMEOUT - 1; c++) step();
    chk("tmo_err_early", 64'(err), 64'd0);
    step();
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_idle", 64'(busy), 64'd0);
    step();
    chk("tmo_next_addr", bus_req, 64'h8000);
    chk("tmo_next_ack", 64'(m_reqack), 64'b00);
    m_reqcyc = 2'b00;
    step();

    // Stray response while idle.
    do_reset();
    bus_respcyc = 1;
    #1;
    chk("stray_respack", 64'(bus_respack), 64'd1);
    chk("stray_err_pre", 64'(err), 64'd0);
    step();
    bus_respcyc = 0;
    #1;
    chk("stray_err", 64'(err), 64'd1);

    // Tag id mismatch: data still routed.
    do_reset();
    m_reqcyc = 2'b01; m_req[0] = 64'h3000; m_reqtag[0] = {1'b0, MEM, 8'h00};
    step();
    bus_reqack = 1;
    step();
    bus_reqack = 0; m_reqcyc = 2'b00;
    bus_respcyc = 1; bus_resp = 64'h55; bus_resptag = {1'b0, MEM, 8'h05};
    #1;
    chk("mm_resp", m_resp, 64'h55);
    chk("mm_respcyc", 64'(m_respcyc), 64'b01);
    step();
    chk("mm_err", 64'(err), 64'd1);
    bus_resptag = {1'b0, MEM, 8'h00};
    for (int k = 0; k < BEATS - 1; k++) step();
    bus_respcyc = 0;
    #1;
    chk("mm_done_busy", 64'(busy), 64'd0);

    // Async reset in the middle of a read burst.
    do_reset();
    bus_respcyc = 1;
    step();
    bus_respcyc = 0;
    m_reqcyc = 2'b01; m_req[0] = 64'h4000; m_reqtag[0] = {1'b0, MEM, 8'h00};
    step();
    bus_reqack = 1;
    step();
    bus_reqack = 0; m_reqcyc = 2'b00;
    bus_respcyc = 1; bus_resptag = {1'b0, MEM, 8'h00};
    for (int k = 0; k < 3; k++) begin
      bus_resp = 64'h10 + 64'(k);
      step();
    end
    bus_resp = 64'h13;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_outputs", {62'(0), m_respcyc} | 64'(m_reqack) | m_resp | bus_req |
        64'({bus_reqcyc, bus_respack, bus_reqtag}), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    step();
    bus_respcyc = 0; bus_resp = '0;
    reset_n = 1'b1;
    m_reqcyc = 2'b11;
    m_req[0] = 64'h5000; m_reqtag[0] = {1'b0, MEM, 8'h01};
    m_req[1] = 64'h6000; m_reqtag[1] = {1'b0, MEM, 8'h02};
    step();
    chk("arst_tie_addr", bus_req, 64'h5000);
    m_reqcyc = 2'b00;
    step();

    // Randomized traffic, each segment starting from reset.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      rnd_on = 1;
      for (int n = 0; n < 700; n++) begin
        gen_inputs();
        step();
      end
      rnd_on = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
